// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit controller.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC0,
        ACC1,
        RESP
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores accept only the signed-width codes; loads also accept the unsigned ones.
    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // One bit per byte touched by the access, right-justified.
    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // True when the access runs past the end of its aligned word.
    function automatic logic is_split(input logic [2:0] f3, input logic [1:0] off);
        logic s;
        case (f3[1:0])
            2'b00:   s = 1'b0;
            2'b01:   s = (off == 2'd3);
            default: s = (off != 2'd0);
        endcase
        return s;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load-data extraction: shifts the two-word window down to the
// addressed byte and sign- or zero-extends according to the load width.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    // Select the addressed bytes, then extend them to a full register value.
    always_comb begin
        shifted = 32'({hi, lo} >> {offset, 3'b000});
        case (funct3)
            F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   rdata = {24'b0, shifted[7:0]};
            F3_HU:   rdata = {16'b0, shifted[15:0]};
            default: rdata = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: turns one memory-stage request into one or two
// aligned word accesses, stalling the pipeline until the result is ready.
module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    lsu_state_e  state, state_next;
    logic        q_we;
    logic [2:0]  q_funct3;
    logic [31:0] q_addr;
    logic [31:0] q_wdata;
    logic [31:0] lo_word;
    logic [31:0] align_lo, align_hi, align_out;
    logic        split;
    logic [31:0] base_addr;
    logic [7:0]  be_span;
    logic [63:0] wdata_span;

    assign split      = is_split(q_funct3, q_addr[1:0]);
    assign base_addr  = {q_addr[31:2], 2'b00};
    assign be_span    = {4'b0000, size_mask(q_funct3)} << q_addr[1:0];
    assign wdata_span = {32'b0, q_wdata} << {q_addr[1:0], 3'b000};
    assign stall      = req_valid && (state != RESP);
    assign done       = (state == RESP);

    load_align u_align (
        .lo     (align_lo),
        .hi     (align_hi),
        .offset (q_addr[1:0]),
        .funct3 (q_funct3),
        .rdata  (align_out)
    );

    // State register; reset drops any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and memory-port drive; the upper and lower halves of the
    // byte-enable and data spans feed the second and first access respectively.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'b0;
        mem_be     = 4'b0;
        mem_wdata  = 32'b0;
        align_lo   = lo_word;
        align_hi   = 32'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = funct3_legal(req_we, req_funct3) ? ACC0 : RESP;
                end
            end
            ACC0: begin
                mem_req   = 1'b1;
                mem_we    = q_we;
                mem_addr  = base_addr;
                mem_be    = q_we ? be_span[3:0] : 4'b1111;
                mem_wdata = q_we ? wdata_span[31:0] : 32'b0;
                align_lo  = mem_rdata;
                if (mem_ack) begin
                    state_next = split ? ACC1 : RESP;
                end
            end
            ACC1: begin
                mem_req   = 1'b1;
                mem_we    = q_we;
                mem_addr  = base_addr + 32'd4;
                mem_be    = q_we ? be_span[7:4] : 4'b1111;
                mem_wdata = q_we ? wdata_span[63:32] : 32'b0;
                align_hi  = mem_rdata;
                if (mem_ack) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture, low-word latch, and result registers that update only
    // on the way into RESP so they hold steady between requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_we     <= 1'b0;
            q_funct3 <= 3'b0;
            q_addr   <= 32'b0;
            q_wdata  <= 32'b0;
            lo_word  <= 32'b0;
            rdata    <= 32'b0;
            err      <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                q_we     <= req_we;
                q_funct3 <= req_funct3;
                q_addr   <= req_addr;
                q_wdata  <= req_wdata;
            end
            if (state == ACC0 && mem_ack) begin
                lo_word <= mem_rdata;
            end
            if (state_next == RESP && state != RESP) begin
                if (state == IDLE) begin
                    err   <= 1'b1;
                    rdata <= 32'b0;
                end else begin
                    err <= 1'b0;
                    if (!q_we) begin
                        rdata <= align_out;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: a word memory responder with per-access
// ack delays, and a byte-level reference model of loads and stores.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, done, err;
    logic [31:0] rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } acc_t;

    logic [31:0] mem [logic [31:0]];
    acc_t        acc_log[$];
    acc_t        exp_log[$];
    int          delays[2];
    int          acc_cnt;
    int          waited;
    int          total = 0;
    int          bad = 0;

    lsu_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .done       (done),
        .rdata      (rdata),
        .err        (err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Unwritten words read back as a fixed function of their address.
    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5C3_0F17;
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic legal(input logic we, input logic [2:0] f3);
        if (we) return (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
        return (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b101);
    endfunction

    // Load value assembled byte by byte from consecutive addresses.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
        int          sz;
        logic [31:0] v, ba, w;
        sz = size_of(f3);
        v  = 32'b0;
        for (int i = 0; i < sz; i++) begin
            ba = addr + 32'(i);
            w  = rd_word({ba[31:2], 2'b00}) >> (32'(ba[1:0]) * 8);
            v[8*i +: 8] = w[7:0];
        end
        if (!f3[2] && sz < 4 && v[8*sz-1]) begin
            for (int i = 8 * sz; i < 32; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Memory responder: drives ack/data half a cycle ahead of the DUT's sampling
    // edge and logs every completed access; ack outside an access is random noise.
    always @(negedge clk) begin
        if (mem_req) begin
            mem_ack   = (waited >= delays[(acc_cnt > 1) ? 1 : acc_cnt]);
            mem_rdata = rd_word(mem_addr);
            if (mem_ack) begin
                acc_t        a;
                logic [31:0] w;
                a.we = mem_we; a.addr = mem_addr; a.be = mem_be; a.wdata = mem_wdata;
                acc_log.push_back(a);
                if (mem_we) begin
                    w = rd_word(mem_addr);
                    for (int k = 0; k < 4; k++) if (mem_be[k]) w[8*k +: 8] = mem_wdata[8*k +: 8];
                    mem[mem_addr] = w;
                end
                waited = 0;
                acc_cnt++;
            end else begin
                waited++;
            end
        end else begin
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Runs one request to completion and checks latency, result and memory traffic.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int d0, input int d1, input string tag);
        logic        ok;
        int          sz, n, exp_cycles, cycle;
        logic [31:0] exp_rdata, w0, ba;
        logic [3:0]  be0, be1;
        logic [63:0] span;
        acc_t        e;

        ok = legal(we, f3);
        sz = size_of(f3);
        n  = !ok ? 0 : ((32'(addr[1:0]) + 32'(sz) > 4) ? 2 : 1);
        exp_cycles = !ok ? 2 : (2 + n + d0 + ((n == 2) ? d1 : 0));
        exp_rdata  = (ok && !we) ? model_load(f3, addr) : 32'b0;
        w0   = {addr[31:2], 2'b00};
        be0  = 4'b0;
        be1  = 4'b0;
        for (int i = 0; i < sz; i++) begin
            ba = addr + 32'(i);
            if ({ba[31:2], 2'b00} == w0) be0[ba[1:0]] = 1'b1;
            else be1[ba[1:0]] = 1'b1;
        end
        span = 64'(wdata) << (32'(addr[1:0]) * 8);
        exp_log.delete();
        for (int k = 0; k < n; k++) begin
            e.we    = we;
            e.addr  = w0 + 32'(4 * k);
            e.be    = !we ? 4'b1111 : ((k == 0) ? be0 : be1);
            e.wdata = !we ? 32'b0 : ((k == 0) ? span[31:0] : span[63:32]);
            exp_log.push_back(e);
        end

        acc_log.delete();
        delays[0] = d0;
        delays[1] = d1;
        acc_cnt = 0;
        waited  = 0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        #1;
        checkOutput({tag, " stall@accept"}, 32'(stall), 32'd1);
        cycle = 1;
        while (!done && cycle < 60) begin
            @(negedge clk);
            #1;
            cycle++;
            if (!done) checkOutput({tag, " stall@wait"}, 32'(stall), 32'd1);
        end
        checkOutput({tag, " done"}, 32'(done), 32'd1);
        checkOutput({tag, " latency"}, 32'(cycle), 32'(exp_cycles));
        checkOutput({tag, " stall@resp"}, 32'(stall), 32'd0);
        checkOutput({tag, " err"}, 32'(err), 32'(!ok));
        if (!we || !ok) checkOutput({tag, " rdata"}, rdata, exp_rdata);
        req_valid = 1'b0;
        checkOutput({tag, " access count"}, 32'(acc_log.size()), 32'(n));
        for (int k = 0; k < n && k < acc_log.size(); k++) begin
            checkOutput({tag, " acc we"}, 32'(acc_log[k].we), 32'(exp_log[k].we));
            checkOutput({tag, " acc addr"}, acc_log[k].addr, exp_log[k].addr);
            checkOutput({tag, " acc be"}, 32'(acc_log[k].be), 32'(exp_log[k].be));
            checkOutput({tag, " acc wdata"}, acc_log[k].wdata, exp_log[k].wdata);
        end
        @(negedge clk);
        #1;
        checkOutput({tag, " idle done"}, 32'(done), 32'd0);
        checkOutput({tag, " idle port"}, {mem_req, mem_we, mem_be, 26'b0}, 32'b0);
        checkOutput({tag, " idle wdata"}, mem_wdata, 32'b0);
        if (!we || !ok) checkOutput({tag, " rdata hold"}, rdata, exp_rdata);
    endtask

    // Directed scenarios first, then randomized traffic, then the summary.
    initial begin
        logic [31:0] pre;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        we;

        delays[0] = 0; delays[1] = 0; acc_cnt = 0; waited = 0;
        mem_ack = 1'b0; mem_rdata = 32'b0;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'b0; req_wdata = 32'b0;
        #1;
        checkOutput("reset stall", 32'(stall), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset err", 32'(err), 32'd0);
        checkOutput("reset rdata", rdata, 32'b0);
        checkOutput("reset mem_req", 32'(mem_req), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        mem[32'h100] = 32'h89ABCDEF;
        applyStimulus(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, "lw aligned");
        checkOutput("lw aligned value", rdata, 32'h89ABCDEF);

        mem[32'h100] = 32'h80112233;
        mem[32'h104] = 32'h445566FF;
        applyStimulus(1'b0, 3'b001, 32'h103, 32'h0, 0, 0, "lh split");
        checkOutput("lh split value", rdata, 32'hFFFFFF80);
        applyStimulus(1'b0, 3'b101, 32'h103, 32'h0, 1, 2, "lhu split");
        checkOutput("lhu split value", rdata, 32'h0000FF80);

        applyStimulus(1'b1, 3'b010, 32'h102, 32'hDEADBEEF, 0, 0, "sw split");
        checkOutput("sw be0", 32'(acc_log[0].be), 32'b1100);
        checkOutput("sw wdata0", acc_log[0].wdata, 32'hBEEF0000);
        checkOutput("sw addr1", acc_log[1].addr, 32'h104);
        checkOutput("sw be1", 32'(acc_log[1].be), 32'b0011);
        checkOutput("sw wdata1", acc_log[1].wdata, 32'h0000DEAD);

        applyStimulus(1'b0, 3'b011, 32'h100, 32'h0, 0, 0, "illegal f3");
        applyStimulus(1'b0, 3'b010, 32'h104, 32'h0, 0, 0, "after illegal");
        applyStimulus(1'b1, 3'b100, 32'h108, 32'h12345678, 0, 0, "illegal store f3");
        applyStimulus(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 0, 1, "lw wrap");

        applyStimulus(1'b0, 3'b010, 32'h101, 32'h0, 0, 3, "lw slow acc1");

        pre = rd_word(32'h200);
        acc_log.delete();
        delays[0] = 0; delays[1] = 1000; acc_cnt = 0; waited = 0;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h202; req_wdata = 32'h13579BDF;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("mid acc1 mem_req", 32'(mem_req), 32'd1);
        checkOutput("mid acc1 addr", mem_addr, 32'h204);
        reset = 1'b1;
        req_valid = 1'b0;
        #1;
        checkOutput("abort stall", 32'(stall), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort mem_req", 32'(mem_req), 32'd0);
        checkOutput("abort rdata", rdata, 32'b0);
        checkOutput("abort access count", 32'(acc_log.size()), 32'd1);
        checkOutput("abort first half", rd_word(32'h200), {16'h9BDF, pre[15:0]});
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 3'b000, 32'h203, 32'h0, 0, 0, "after abort");

        for (int t = 0; t < 40; t++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
            else if (we) f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'b011) f3 = 3'b100;
                else if (f3 == 3'b100) f3 = 3'b101;
            end
            if ($urandom_range(0, 5) == 0) addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            else addr = 32'h300 + 32'($urandom_range(0, 31));
            applyStimulus(we, f3, addr, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single clock, all state rising-edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port req_valid  in  1  memory-stage load/store request, held stable while stall=1.
REQ-004 SHALL have port req_we  in  1  1=store, 0=load.
REQ-005 SHALL have port req_funct3  in  3  RV32I width/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
REQ-006 SHALL have port req_addr  in  32  byte address (ALU result).
REQ-007 SHALL have port req_wdata  in  32  store data, right-justified.
REQ-008 SHALL have port stall  out  1  hold pipeline.
REQ-009 SHALL have port done  out  1  one-cycle completion pulse.
REQ-010 SHALL have port rdata  out  32  extended load result, valid when done=1.
REQ-011 SHALL have port err  out  1  illegal funct3, valid when done=1.
REQ-012 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 32 (bits [1:0]=00), mem_be out 4, mem_wdata out 32, mem_rdata in 32, mem_ack in 1.

Function
REQ-013 SHALL implement states IDLE, ACC0, ACC1, RESP.
REQ-014 IDLE: on req_valid SHALL register the request, go ACC0; legal funct3 required for memory access, else go RESP with err=1, no mem_req.
REQ-015 stall SHALL equal req_valid AND state!=RESP; done=1 and stall=0 only in RESP; RESP always returns to IDLE next cycle.
REQ-016 ACC0: mem_req=1, mem_addr={addr[31:2],00}; held until mem_ack; on ack latch mem_rdata as lo word, go ACC1 if split else RESP.
REQ-017 Split SHALL mean offset+size>4 (size 1/2/4 bytes, offset=addr[1:0]): LH/LHU/SH at offset 3; LW/SW at offsets 1–3.
REQ-018 ACC1: mem_addr = ACC0 address + 4 (wraps mod 2^32 at 0xFFFFFFFC); latch hi word on ack; go RESP.
REQ-019 Store byte enables: mask=(0001,0011,1111) per size; ACC0 mem_be=(mask<<offset)[3:0], ACC1 mem_be=mask>>(4-offset); mem_wdata = wdata<<8*offset (ACC0), wdata>>8*(4-offset) (ACC1). Low word always written first.
REQ-020 Loads SHALL drive mem_be=1111, mem_we=0.
REQ-021 rdata SHALL be ({hi,lo}>>8*offset)[31:0] (hi=0 if not split), then sign-extend (000,001) or zero-extend (100,101) from size; LW unchanged; err case rdata=0.
REQ-022 mem_ack outside ACC0/ACC1 SHALL be ignored; mem_we, mem_be, mem_wdata SHALL be 0 when mem_req=0.
REQ-023 rdata and err SHALL hold last value outside RESP.
REQ-024 Latency: aligned access with same-cycle ack: done 3 cycles after acceptance edge; split: 4; each mem wait cycle adds 1.

Reset
REQ-025 reset SHALL asynchronously force IDLE, stall/done/err/mem_req=0, rdata=0, captured request cleared; reset mid-ACC1 SHALL abandon the access (first half of split store remains written).

Structure
REQ-026 SHALL place state enum and funct3 constants in shared package lsu_pkg.
REQ-027 SHALL instantiate one sub-module load_align (combinational: lo, hi, offset, funct3 -> rdata).

Verification
REQ-028 LW 0x100, mem word 0x89ABCDEF, ack immediate -> done at cycle 3, rdata=0x89ABCDEF, one mem access.
REQ-029 LH 0x103, word@0x100=0x80112233, word@0x104=0x445566FF -> two accesses (0x100, 0x104), rdata=0xFFFFFF80; LHU -> 0x0000FF80.
REQ-030 SW 0x102 data 0xDEADBEEF -> ACC0 addr 0x100 be 1100 wdata 0xBEEF0000; ACC1 addr 0x104 be 0011 wdata 0x0000DEAD.
REQ-031 funct3=011 load -> no mem_req, done with err=1, rdata=0; next request accepted normally.
REQ-032 mem_ack delayed 3 cycles in ACC1, then reset asserted mid-ACC1 in a second run -> first run completes at cycle 7; second run returns to IDLE immediately, stall=0.
